cacheline_adapter: RTL and testbench

CACHELINE_ADAPTER -- requirements
Module: cacheline_adapter

---
 rtl/cacheline_adapter.sv | 139 +++++++++++++
 tb/tb_cacheline_adapter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cacheline_adapter.sv
// rtl/cacheline_adapter.sv - 256-bit cache line to 4x64-bit memory burst adapter
module cacheline_adapter (
  input  logic         clk,
  input  logic         rst,
  // cache side
  input  logic [255:0] line_i,
  output logic [255:0] line_o,
  input  logic [31:0]  address_i,
  input  logic         read_i,
  input  logic         write_i,
  output logic         resp_o,
  // physical memory side
  input  logic [63:0]  burst_i,
  output logic [63:0]  burst_o,
  output logic [31:0]  address_o,
  output logic         read_o,
  output logic         write_o,
  input  logic         resp_i
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e         state_q, state_d;
  logic [1:0]     cnt_q, cnt_d;
  logic [31:0]    addr_q, addr_d;
  logic [255:0]   wline_q, wline_d;
  logic [255:0]   line_q, line_d;

  // Outputs are registered; their next values are derived from the next state
  // so they line up with the state they describe.
  logic           read_q, read_d;
  logic           write_q, write_d;
  logic           resp_q, resp_d;
  logic [63:0]    burst_q, burst_d;
  logic [31:0]    aout_q, aout_d;

  // Next-state, beat counter and line/address capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wline_d = wline_q;
    line_d  = line_q;
    case (state_q)
      IDLE: begin
        // read wins when both requests are raised together
        if (read_i) begin
          state_d = READ;
          addr_d  = {address_i[31:5], 5'b0};
          cnt_d   = 2'd0;
        end else if (write_i) begin
          state_d = WRITE;
          addr_d  = {address_i[31:5], 5'b0};
          wline_d = line_i;
          cnt_d   = 2'd0;
        end
      end
      READ: begin
        if (resp_i) begin
          line_d[{cnt_q, 6'b0} +: 64] = burst_i;
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d = DONE;
          end
        end
      end
      WRITE: begin
        if (resp_i) begin
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        // one-cycle completion, then always back through IDLE
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output values for the cycle following this edge.
  always_comb begin
    read_d  = (state_d == READ);
    write_d = (state_d == WRITE);
    resp_d  = (state_d == DONE);
    aout_d  = 32'd0;
    burst_d = 64'd0;
    if ((state_d == READ) || (state_d == WRITE)) begin
      aout_d = addr_d;
    end
    if (state_d == WRITE) begin
      burst_d = wline_d[{cnt_d, 6'b0} +: 64];
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      addr_q  <= 32'd0;
      wline_q <= 256'd0;
      line_q  <= 256'd0;
      read_q  <= 1'b0;
      write_q <= 1'b0;
      resp_q  <= 1'b0;
      burst_q <= 64'd0;
      aout_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wline_q <= wline_d;
      line_q  <= line_d;
      read_q  <= read_d;
      write_q <= write_d;
      resp_q  <= resp_d;
      burst_q <= burst_d;
      aout_q  <= aout_d;
    end
  end

  assign line_o    = line_q;
  assign read_o    = read_q;
  assign write_o   = write_q;
  assign resp_o    = resp_q;
  assign burst_o   = burst_q;
  assign address_o = aout_q;

endmodule

// File: tb/tb_cacheline_adapter.sv
// tb/tb_cacheline_adapter.sv - self-checking bench for cacheline_adapter
module tb_cacheline_adapter;

  logic         clk;
  logic         rst;
  logic [255:0] line_i;
  logic [255:0] line_o;
  logic [31:0]  address_i;
  logic         read_i;
  logic         write_i;
  logic         resp_o;
  logic [63:0]  burst_i;
  logic [63:0]  burst_o;
  logic [31:0]  address_o;
  logic         read_o;
  logic         write_o;
  logic         resp_i;

  int total;
  int bad;

  cacheline_adapter dut (
    .clk       (clk),
    .rst       (rst),
    .line_i    (line_i),
    .line_o    (line_o),
    .address_i (address_i),
    .read_i    (read_i),
    .write_i   (write_i),
    .resp_o    (resp_o),
    .burst_i   (burst_i),
    .burst_o   (burst_o),
    .address_o (address_o),
    .read_o    (read_o),
    .write_o   (write_o),
    .resp_i    (resp_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Transaction-level reference: what kind of operation is in progress,
  // how many beats have moved, and the words involved.
  string       m_mode;     // "idle", "read", "write", "done"
  int          m_beats;
  logic [31:0] m_addr;
  logic [63:0] m_wwords [4];
  logic [63:0] m_rwords [4];
  bit          m_valid;

  initial begin
    m_valid = 0;
    m_mode  = "idle";
    m_beats = 0;
    m_addr  = '0;
    for (int i = 0; i < 4; i++) begin
      m_wwords[i] = '0;
      m_rwords[i] = '0;
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      m_valid = 1;
      m_mode  = "idle";
      m_beats = 0;
      m_addr  = '0;
      for (int i = 0; i < 4; i++) begin
        m_wwords[i] = '0;
        m_rwords[i] = '0;
      end
    end else if (m_mode == "idle") begin
      if (read_i) begin
        m_mode  = "read";
        m_beats = 0;
        m_addr  = address_i & 32'hFFFF_FFE0;
      end else if (write_i) begin
        m_mode  = "write";
        m_beats = 0;
        m_addr  = address_i & 32'hFFFF_FFE0;
        for (int i = 0; i < 4; i++) m_wwords[i] = line_i[i*64 +: 64];
      end
    end else if (m_mode == "read" || m_mode == "write") begin
      if (resp_i) begin
        if (m_mode == "read") m_rwords[m_beats] = burst_i;
        m_beats = m_beats + 1;
        if (m_beats == 4) begin
          m_mode  = "done";
          m_beats = 0;
        end
      end
    end else begin
      m_mode = "idle";
    end
  end

  // Per-cycle comparison against the reference, away from the active edge.
  always @(negedge clk) begin
    logic [255:0] exp_line;
    logic [63:0]  exp_burst;
    logic [31:0]  exp_addr;
    if (m_valid) begin
      exp_line  = {m_rwords[3], m_rwords[2], m_rwords[1], m_rwords[0]};
      exp_burst = (m_mode == "write") ? m_wwords[m_beats] : 64'd0;
      exp_addr  = (m_mode == "read" || m_mode == "write") ? m_addr : 32'd0;
      total++;
      if (read_o !== (m_mode == "read") || write_o !== (m_mode == "write") ||
          resp_o !== (m_mode == "done") || address_o !== exp_addr ||
          burst_o !== exp_burst || line_o !== exp_line) begin
        bad++;
        $display("FAIL model t=%0t: rd=%b wr=%b resp=%b addr=%h burst=%h line=%h expected rd=%b wr=%b resp=%b addr=%h burst=%h line=%h",
                 $time, read_o, write_o, resp_o, address_o, burst_o, line_o,
                 (m_mode == "read"), (m_mode == "write"), (m_mode == "done"),
                 exp_addr, exp_burst, exp_line);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  localparam logic [63:0] R0 = 64'hA5A5_0000_0000_0000;
  localparam logic [63:0] R1 = 64'hA5A5_0000_0000_0011;
  localparam logic [63:0] R2 = 64'hA5A5_0000_0000_0022;
  localparam logic [63:0] R3 = 64'hA5A5_0000_0000_0033;
  localparam logic [63:0] WA = 64'h1111_1111_1111_1111;
  localparam logic [63:0] WB = 64'h2222_2222_2222_2222;
  localparam logic [63:0] WC = 64'h3333_3333_3333_3333;
  localparam logic [63:0] WD = 64'h4444_4444_4444_4444;

  initial begin
    logic [63:0] rb [4];
    logic [63:0] ww [4];
    int          gaps [7];
    int          idx;
    total = 0;
    bad   = 0;
    rst = 1; line_i = '0; address_i = '0; read_i = 0; write_i = 0;
    burst_i = '0; resp_i = 0;
    tick(); tick();
    chk("reset_line", line_o, 256'd0);
    chk("reset_ctl", {252'd0, read_o, write_o, resp_o, |burst_o}, 256'd0);
    chk("reset_addr", {224'd0, address_o}, 256'd0);
    rst = 0;

    // Read without gaps
    rb[0] = R0; rb[1] = R1; rb[2] = R2; rb[3] = R3;
    address_i = 32'h1234_5678; read_i = 1;
    tick();
    chk("rd_addr", {224'd0, address_o}, {224'd0, 32'h1234_5660});
    for (int k = 0; k < 4; k++) begin
      chk("rd_read_o", {255'd0, read_o}, 256'd1);
      chk("rd_no_resp", {255'd0, resp_o}, 256'd0);
      resp_i = 1; burst_i = rb[k];
      tick();
    end
    resp_i = 0;
    chk("rd_resp", {255'd0, resp_o}, 256'd1);
    chk("rd_read_low", {255'd0, read_o}, 256'd0);
    chk("rd_line", line_o, {R3, R2, R1, R0});
    read_i = 0;
    tick();
    chk("rd_resp_one_cycle", {255'd0, resp_o}, 256'd0);

    // Write with gaps; inputs scrambled after acceptance
    ww[0] = WA; ww[1] = WB; ww[2] = WC; ww[3] = WD;
    gaps[0] = 1; gaps[1] = 0; gaps[2] = 1; gaps[3] = 0;
    gaps[4] = 0; gaps[5] = 1; gaps[6] = 1;
    line_i = {WD, WC, WB, WA}; address_i = 32'h0000_ABFF; write_i = 1;
    tick();
    line_i = {4{64'hDEAD_BEEF_DEAD_BEEF}}; address_i = 32'hFFFF_FFFF;
    chk("wr_addr", {224'd0, address_o}, {224'd0, 32'h0000_ABE0});
    idx = 0;
    for (int p = 0; p < 7; p++) begin
      chk("wr_burst", {192'd0, burst_o}, {192'd0, ww[idx]});
      chk("wr_write_o", {255'd0, write_o}, 256'd1);
      resp_i = gaps[p][0];
      tick();
      idx += gaps[p];
    end
    resp_i = 0;
    chk("wr_resp", {255'd0, resp_o}, 256'd1);
    chk("wr_burst_zero", {192'd0, burst_o}, 256'd0);
    chk("wr_line_kept", line_o, {R3, R2, R1, R0});
    write_i = 0;
    tick();

    // Simultaneous read and write: read wins
    read_i = 1; write_i = 1; address_i = 32'h0000_0040;
    tick();
    chk("both_read_o", {255'd0, read_o}, 256'd1);
    chk("both_write_o", {255'd0, write_o}, 256'd0);
    for (int k = 0; k < 4; k++) begin
      resp_i = 1; burst_i = 64'hC000 + 64'(k);
      tick();
    end
    resp_i = 0;
    chk("both_line", line_o, {64'hC003, 64'hC002, 64'hC001, 64'hC000});
    read_i = 0; write_i = 0;
    tick();

    // Reset mid-read after two beats
    read_i = 1; address_i = 32'h0000_1000;
    tick();
    for (int k = 0; k < 2; k++) begin
      resp_i = 1; burst_i = 64'hE000 + 64'(k);
      tick();
    end
    resp_i = 0; rst = 1;
    tick();
    rst = 0;
    chk("rst_mid_ctl", {252'd0, read_o, write_o, resp_o, |burst_o}, 256'd0);
    chk("rst_mid_line", line_o, 256'd0);
    tick();
    chk("rst_new_read", {255'd0, read_o}, 256'd1);
    for (int k = 0; k < 4; k++) begin
      resp_i = 1; burst_i = 64'hF000 + 64'(k);
      tick();
    end
    resp_i = 0;
    chk("rst_after_resp", {255'd0, resp_o}, 256'd1);
    chk("rst_after_line", line_o, {64'hF003, 64'hF002, 64'hF001, 64'hF000});

    // Back-to-back: read_i held through resp_o, spurious beat in the IDLE cycle
    tick();
    chk("b2b_idle_read_o", {255'd0, read_o}, 256'd0);
    chk("b2b_idle_resp_o", {255'd0, resp_o}, 256'd0);
    resp_i = 1; burst_i = 64'hBAD0_BAD0_BAD0_BAD0;
    tick();
    chk("b2b_second_read", {255'd0, read_o}, 256'd1);
    for (int k = 0; k < 4; k++) begin
      resp_i = 1; burst_i = 64'h7000 + 64'(k);
      tick();
    end
    resp_i = 0; read_i = 0;
    chk("b2b_resp", {255'd0, resp_o}, 256'd1);
    chk("b2b_line", line_o, {64'h7003, 64'h7002, 64'h7001, 64'h7000});
    tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
